// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite single-transfer master: queues word read/write commands in a small FIFO and
// issues one NONSEQ transfer at a time, returning data, error and wait-state count.
module ahb_lite_cmd_master #(
  parameter int ADDR_W    = 32,
  parameter int CMD_DEPTH = 4,
  parameter int WAIT_W    = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [WAIT_W-1:0] rsp_wait,
  output logic              busy,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (&v) ? v : v + WAIT_W'(1);
  endfunction

  logic              fifo_write [CMD_DEPTH];
  logic [ADDR_W-1:0] fifo_addr  [CMD_DEPTH];
  logic [31:0]       fifo_wdata [CMD_DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_nxt;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  logic [1:0]        state;
  logic [31:0]       cur_wdata;

  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [31:0]       head_wdata;

  assign cmd_ready  = !full;
  assign push       = cmd_valid && !full;
  assign pop        = (state == ST_IDLE) && !empty && !rsp_valid;
  assign wr_ptr_nxt = wr_ptr + PTR_W'(1);
  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);

  assign head_write = fifo_write[rd_ptr];
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_wdata = fifo_wdata[rd_ptr];

  assign HSIZE  = 3'b010;
  assign HBURST = 3'b000;
  assign busy   = !empty || (state != ST_IDLE) || rsp_valid;

  // Command storage carries no reset; full/empty alone say what is valid.
  always_ff @(posedge HCLK) begin
    if (push) begin
      fifo_write[wr_ptr] <= cmd_write;
      fifo_addr[wr_ptr]  <= cmd_addr;
      fifo_wdata[wr_ptr] <= cmd_wdata;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr_nxt;
      if (pop)  rd_ptr <= rd_ptr_nxt;
      if (push && !pop) begin
        empty <= 1'b0;
        full  <= (wr_ptr_nxt == rd_ptr);
      end else if (pop && !push) begin
        full  <= 1'b0;
        empty <= (rd_ptr_nxt == wr_ptr);
      end
    end
  end

  // Transfer sequencer: one outstanding transfer, address and data phases never overlap.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      HTRANS    <= TR_IDLE;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      cur_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rsp_wait  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            rsp_wait  <= '0;
            rsp_rdata <= '0;
            if (head_addr[1:0] != 2'b00) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              HADDR     <= head_addr;
              HWRITE    <= head_write;
              HTRANS    <= TR_NONSEQ;
              cur_wdata <= head_wdata;
              rsp_err   <= 1'b0;
              state     <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            HTRANS <= TR_IDLE;
            if (HWRITE) HWDATA <= cur_wdata;
            state  <= ST_DATA;
          end else begin
            rsp_wait <= sat_inc(rsp_wait);
          end
        end
        ST_DATA: begin
          // The first ERROR cycle needs nothing: HTRANS is already IDLE.
          if (HREADY) begin
            rsp_err   <= HRESP;
            rsp_rdata <= (!HWRITE && !HRESP) ? HRDATA : 32'h0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            rsp_wait <= sat_inc(rsp_wait);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
